// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data
// ports, with alignment checks, fetch anti-starvation and access timeout.
module mem_port_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic        SYS_clk,
   input  logic        SYS_reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_length,
   input  logic        d_signed,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_length,
   output logic        mem_signed,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

   state_t        state, state_n;
   logic [WW-1:0] wait_cnt, wait_cnt_n;
   logic [TW-1:0] tmo_cnt, tmo_cnt_n;
   logic          resp_d, resp_d_n;
   logic [31:0]   rdata_q, rdata_n;

   logic          if_gnt_n, if_rvalid_n, if_err_n;
   logic          d_gnt_n, d_rvalid_n, d_err_n;
   logic [31:0]   if_rdata_n, d_rdata_n;
   logic          mem_req_n, mem_we_n, mem_signed_n;
   logic [31:0]   mem_addr_n, mem_wdata_n;
   logic [1:0]    mem_length_n;

   logic          if_win, d_win, if_bad, d_bad;

   // Winner selection and alignment legality of the pending requests
   always_comb begin
      if_win = if_req && (!d_req || wait_cnt == WW'(MAX_WAIT));
      d_win  = d_req && !if_win;
      if_bad = (if_addr[1:0] != 2'b00);
      d_bad  = (d_length == 2'b00) ||
               (d_length == 2'b11 && d_addr[1:0] != 2'b00) ||
               (d_length == 2'b10 && d_addr[0]);
   end

   // Next state, counters and next registered outputs
   always_comb begin
      state_n      = state;
      wait_cnt_n   = wait_cnt;
      tmo_cnt_n    = tmo_cnt;
      resp_d_n     = resp_d;
      rdata_n      = rdata_q;
      if_gnt_n     = 1'b0;
      if_rvalid_n  = 1'b0;
      if_err_n     = 1'b0;
      if_rdata_n   = '0;
      d_gnt_n      = 1'b0;
      d_rvalid_n   = 1'b0;
      d_err_n      = 1'b0;
      d_rdata_n    = '0;
      mem_req_n    = mem_req;
      mem_we_n     = mem_we;
      mem_addr_n   = mem_addr;
      mem_wdata_n  = mem_wdata;
      mem_length_n = mem_length;
      mem_signed_n = mem_signed;
      unique case (state)
         IDLE: begin
            if (if_win) begin
               wait_cnt_n = '0;
               if (if_bad) begin
                  if_err_n = 1'b1;
               end else begin
                  if_gnt_n     = 1'b1;
                  mem_req_n    = 1'b1;
                  mem_we_n     = 1'b0;
                  mem_addr_n   = if_addr;
                  mem_wdata_n  = '0;
                  mem_length_n = 2'b11;
                  mem_signed_n = 1'b0;
                  tmo_cnt_n    = '0;
                  state_n      = BUSY_IF;
               end
            end else if (d_win) begin
               if (if_req && wait_cnt != WW'(MAX_WAIT))
                  wait_cnt_n = wait_cnt + 1'b1;
               if (d_bad) begin
                  d_err_n = 1'b1;
               end else begin
                  d_gnt_n      = 1'b1;
                  mem_req_n    = 1'b1;
                  mem_we_n     = d_we;
                  mem_addr_n   = d_addr;
                  mem_wdata_n  = d_wdata;
                  mem_length_n = d_length;
                  mem_signed_n = d_signed;
                  tmo_cnt_n    = '0;
                  state_n      = BUSY_D;
               end
            end
         end
         BUSY_IF, BUSY_D: begin
            if (mem_ready) begin
               mem_req_n = 1'b0;
               rdata_n   = mem_we ? 32'h0 : mem_rdata;
               resp_d_n  = (state == BUSY_D);
               state_n   = RESP;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               mem_req_n = 1'b0;
               if (state == BUSY_D) d_err_n = 1'b1;
               else                 if_err_n = 1'b1;
               state_n   = IDLE;
            end else begin
               tmo_cnt_n = tmo_cnt + 1'b1;
            end
         end
         RESP: begin
            if (resp_d) begin
               d_rvalid_n = 1'b1;
               d_rdata_n  = rdata_q;
            end else begin
               if_rvalid_n = 1'b1;
               if_rdata_n  = rdata_q;
            end
            state_n = IDLE;
         end
      endcase
   end

   // State, counters and all outputs are registered
   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         tmo_cnt    <= '0;
         resp_d     <= 1'b0;
         rdata_q    <= '0;
         if_gnt     <= 1'b0;
         if_rvalid  <= 1'b0;
         if_err     <= 1'b0;
         if_rdata   <= '0;
         d_gnt      <= 1'b0;
         d_rvalid   <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_length <= '0;
         mem_signed <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         wait_cnt   <= wait_cnt_n;
         tmo_cnt    <= tmo_cnt_n;
         resp_d     <= resp_d_n;
         rdata_q    <= rdata_n;
         if_gnt     <= if_gnt_n;
         if_rvalid  <= if_rvalid_n;
         if_err     <= if_err_n;
         if_rdata   <= if_rdata_n;
         d_gnt      <= d_gnt_n;
         d_rvalid   <= d_rvalid_n;
         d_err      <= d_err_n;
         d_rdata    <= d_rdata_n;
         mem_req    <= mem_req_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         mem_length <= mem_length_n;
         mem_signed <= mem_signed_n;
         busy       <= (state_n != IDLE);
      end
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch (IF) and the datapath load/store port (D).
- Sequences each access as a request/grant/response transaction.
- Enforces alignment on every access and a response timeout on every forwarded access.
- Sits between the CPU top level and the unified memory; a multi-cycle core uses it to serialize fetch and data traffic.

Parameters:
- MAX_WAIT, 4, consecutive IF losses before IF is forced to win arbitration.
- TIMEOUT, 16, cycles in BUSY without mem_ready before the access is aborted.

Ports:
- SYS_clk in 1 system clock
- SYS_reset in 1 asynchronous reset, active-low
- if_req in 1 fetch request; held until if_gnt or if_err
- if_addr in 32 fetch address
- if_gnt out 1 one-cycle grant pulse
- if_rvalid out 1 one-cycle response pulse
- if_rdata out 32 fetched word, valid with if_rvalid
- if_err out 1 one-cycle error pulse (misaligned or timeout)
- d_req in 1 data request; held until d_gnt or d_err
- d_we in 1 1 = store, 0 = load
- d_addr in 32 data address
- d_wdata in 32 store data
- d_length in 2 01 byte, 10 half, 11 word, 00 illegal
- d_signed in 1 sign-extend load
- d_gnt out 1 one-cycle grant pulse
- d_rvalid out 1 one-cycle response pulse (loads and stores)
- d_rdata out 32 load data; 0 for stores
- d_err out 1 one-cycle error pulse
- mem_req out 1 access active
- mem_we out 1 write enable
- mem_addr out 32 address
- mem_wdata out 32 write data
- mem_length out 2 access length
- mem_signed out 1 load sign control
- mem_ready in 1 memory completes the access this cycle
- mem_rdata in 32 read data, valid when mem_ready=1
- busy out 1 state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, timeout counter 0.
- Reset mid-transaction abandons the access; mem_req drops asynchronously.
- States: IDLE, BUSY_IF, BUSY_D, RESP. All outputs are registered.
- Arbitration (IDLE, at a clock edge):
  - Both requests present: D wins unless the wait counter equals MAX_WAIT, in which case IF wins.
  - Wait counter increments (saturating at MAX_WAIT) when IF loses; clears when IF is granted or errors.
- Alignment check, made in IDLE before grant:
  - IF access is illegal when if_addr[1:0] != 0.
  - D access is illegal when: length 11 with addr[1:0] != 0; length 10 with addr[0] != 0; or length 00.
  - An illegal winner gets its err pulse next cycle, no gnt, no mem_req; the state stays IDLE.
  - An illegal winner still counts as that requester's turn for the wait counter.
- Legal grant:
  - Next cycle: gnt pulse for one cycle; mem_req=1; mem_* latched from the winner.
  - IF access is always mem_we=0, mem_length=11, mem_signed=0.
  - State becomes BUSY_IF or BUSY_D.
- BUSY state:
  - mem_* held stable until mem_ready=1.
  - On mem_ready=1: capture mem_rdata (0 if store); mem_req=0 next cycle; go to RESP.
- RESP: rvalid pulse with rdata for one cycle, then IDLE.
- Latency: req at cycle N gives gnt and mem_req at N+1. With mem_ready at N+1, rvalid is at N+3. Next grant is no earlier than N+4.
- Timeout:
  - The counter counts cycles in BUSY. When it reaches TIMEOUT with no mem_ready, mem_req drops.
  - The err pulse for the granted requester fires in place of rvalid; the state returns to IDLE.
  - mem_ready in the same cycle as the counter reaching TIMEOUT counts as success.
- A requester dropping req while in BUSY/RESP does not affect the in-flight access.
- A request arriving during BUSY/RESP waits; it is arbitrated only in IDLE.
- gnt, rvalid and err are mutually exclusive per requester per cycle.

Test Plan:
- Reset asserted low during BUSY_D with mem_req=1 -> mem_req=0 immediately; after release busy=0 and all pulses stay 0.
- IF-only fetch, if_addr=0x100, mem_ready at first BUSY cycle, mem_rdata=0x00500293 -> if_gnt at N+1, if_rvalid at N+3 with if_rdata=0x00500293, mem_we=0, mem_length=11.
- Both requesting continuously, mem_ready always 1 -> D granted 4 times, then IF, then the pattern repeats; the wait counter never exceeds 4.
- D store: d_addr=0x202, d_length=10, d_wdata=0xABCD -> d_gnt, mem_we=1, mem_addr=0x202, d_rvalid with d_rdata=0.
- D word load: d_addr=0x203, d_length=11 -> d_err one cycle after req, no d_gnt, mem_req stays 0.
- mem_ready held 0 -> mem_req high for exactly 16 cycles, then d_err pulse, busy=0 next cycle; mem_ready on the 16th cycle -> d_rvalid instead of d_err.
